// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM read arbiter.
// Address/data widths match the single read-only SRAM controller.
package sram_arb_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of elig at or after ptr, wrapping.
// Zero latency; pick is one-hot, vld low when nothing is eligible.
module rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     elig,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             vld
);

  always_comb begin
    int idx;
    pick = '0;
    vld  = 1'b0;
    idx  = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!vld && elig[idx]) begin
        pick[idx] = 1'b1;
        vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_read_arbiter.sv
// Round-robin burst read arbiter in front of the single-port SRAM controller.
// One Read per word, 3 cycles per word; words return registered with a per-requester strobe.
module sram_read_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int LEN_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*SRAM_AW-1:0]   req_addr,
  input  logic [N_REQ*LEN_W-1:0]     req_len,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rd_valid,
  output logic [SRAM_DW-1:0]         rd_data,
  output logic                       rd_last,
  output logic                       busy,
  output logic                       err_timeout,
  output logic                       Read,
  output logic [SRAM_AW-1:0]         addr_in,
  input  logic                       done_r,
  input  logic [SRAM_DW-1:0]         OUTPUT_DATA
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE = 1;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [SRAM_AW-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]     rd_valid_q, rd_valid_d;
  logic [SRAM_DW-1:0]   rd_data_q, rd_data_d;
  logic                 rd_last_q, rd_last_d;
  logic                 err_timeout_q, err_timeout_d;

  logic [N_REQ-1:0]     elig;
  logic [N_REQ-1:0]     pick;
  logic                 pick_vld;
  logic [PTR_W-1:0]     pick_idx;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0);
    end
  end

  rr_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .elig (elig),
    .ptr  (rr_ptr_q),
    .pick (pick),
    .vld  (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    wait_cnt_d    = wait_cnt_q;
    gnt_d         = '0;
    rd_valid_d    = '0;
    rd_last_d     = 1'b0;
    rd_data_d     = rd_data_q;
    err_timeout_d = err_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d       = pick;
          owner_d     = pick_idx;
          cur_addr_d  = req_addr[pick_idx*SRAM_AW +: SRAM_AW];
          remaining_d = req_len[pick_idx*LEN_W +: LEN_W];
          rr_ptr_d    = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (done_r) begin
          rd_data_d   = OUTPUT_DATA;
          rd_valid_d  = ONE << owner_q;
          rd_last_d   = (remaining_q == LEN_W'(1));
          cur_addr_d  = cur_addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = (remaining_q == LEN_W'(1)) ? IDLE : ISSUE;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort the whole burst with a zero word so the requester still sees a last.
          err_timeout_d = 1'b1;
          rd_valid_d    = ONE << owner_q;
          rd_last_d     = 1'b1;
          rd_data_d     = '0;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      wait_cnt_q    <= '0;
      gnt_q         <= '0;
      rd_valid_q    <= '0;
      rd_last_q     <= 1'b0;
      rd_data_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      wait_cnt_q    <= wait_cnt_d;
      gnt_q         <= gnt_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
      rd_data_q     <= rd_data_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign gnt         = gnt_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_last     = rd_last_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q != IDLE);
  assign Read        = (state_q == ISSUE);
  assign addr_in     = cur_addr_q;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: directed scenarios plus random traffic against a
// schedule-based reference (burst start cycle + word index arithmetic).
module tb_sram_read_arbiter;

  localparam int N_REQ   = 2;
  localparam int LEN_W   = 6;
  localparam int TIMEOUT = 15;

  logic                   Clk;
  logic                   Reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*20-1:0]    req_addr;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rd_valid;
  logic [15:0]            rd_data;
  logic                   rd_last;
  logic                   busy;
  logic                   err_timeout;
  logic                   Read;
  logic [19:0]            addr_in;
  logic                   done_r;
  logic [15:0]            OUTPUT_DATA;

  sram_read_arbiter #(
    .N_REQ   (N_REQ),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req         (req),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .gnt         (gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .busy        (busy),
    .err_timeout (err_timeout),
    .Read        (Read),
    .addr_in     (addr_in),
    .done_r      (done_r),
    .OUTPUT_DATA (OUTPUT_DATA)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one burst in flight, described by its start cycle.
  int           cyc = 0;
  bit           m_active = 0;
  int           m_g = 0;
  int           m_len = 0;
  int           m_owner = 0;
  logic [19:0]  m_base = '0;
  bit           m_tmo = 0;
  int           m_rr = 0;
  bit           m_err = 0;
  bit           m_rst_prev = 1;

  // Requester and controller stimulus state.
  bit           pending [N_REQ];
  logic [19:0]  p_addr  [N_REQ];
  int           p_len   [N_REQ];
  bit           rand_arm = 0;
  bit           hold_rst = 1;
  int           rst_at_d = -1;
  bit           resp_en = 1;
  bit           stray_en = 0;
  logic         rd_d1 = 0, rd_d2 = 0;
  logic [19:0]  a_d1 = '0, a_d2 = '0;

  function automatic int burst_end();
    return m_tmo ? TIMEOUT + 1 : 3 * m_len;
  endfunction

  task automatic arm(input int i, input logic [19:0] addr, input int len);
    if (!pending[i]) begin
      pending[i] = 1;
      p_addr[i]  = addr;
      p_len[i]   = len;
    end
  endtask

  task automatic check_outputs();
    logic [N_REQ-1:0] e_gnt, e_vld;
    logic             e_busy, e_read, e_last, chk_addr;
    logic [15:0]      e_data;
    logic [19:0]      e_addr, w_addr;
    int               d, endd, k;
    e_gnt = '0; e_vld = '0; e_busy = 0; e_read = 0; e_last = 0; chk_addr = 0;
    e_data = '0; e_addr = '0; w_addr = '0; d = 0; endd = 0; k = 0;
    if (m_active) begin
      d    = cyc - m_g;
      endd = burst_end();
      if (d == 0) e_gnt[m_owner] = 1'b1;
      if (d < endd) begin
        e_busy   = 1;
        e_read   = m_tmo ? (d == 0) : (d % 3 == 0);
        e_addr   = m_base + 20'(m_tmo ? 0 : d / 3);
        chk_addr = 1;
      end
      if (m_tmo && d == endd) begin
        e_vld[m_owner] = 1'b1;
        e_last = 1;
        e_data = '0;
        m_err  = 1;
      end else if (!m_tmo && d > 0 && d % 3 == 0) begin
        k      = d / 3 - 1;
        w_addr = m_base + 20'(k);
        e_vld[m_owner] = 1'b1;
        e_last = (k == m_len - 1);
        e_data = 16'h00A0 + w_addr[15:0];
      end
    end
    chk("gnt", gnt, e_gnt);
    chk("rd_valid", rd_valid, e_vld);
    chk("busy", busy, e_busy);
    chk("Read", Read, e_read);
    chk("err_timeout", err_timeout, m_err);
    if (chk_addr) chk("addr_in", addr_in, e_addr);
    if (e_vld != '0) begin
      chk("rd_data", rd_data, e_data);
      chk("rd_last", rd_last, e_last);
    end else begin
      chk("rd_last_idle", rd_last, 1'b0);
    end
    if (m_rst_prev) begin
      chk("rst_rd_data", rd_data, 16'h0);
      chk("rst_addr_in", addr_in, 20'h0);
    end
  endtask

  // Controller: done_r two cycles after Read, data = 0xA0 + address.
  task automatic drive_ctrl();
    logic stray;
    stray = stray_en && (!busy || Read) && !rd_d2 && ($urandom_range(0, 3) == 0);
    done_r      = (rd_d2 && resp_en) || stray;
    OUTPUT_DATA = (rd_d2 && resp_en) ? 16'h00A0 + a_d2[15:0] : 16'($urandom);
    rd_d2 = rd_d1;
    a_d2  = a_d1;
    rd_d1 = Read;
    a_d1  = addr_in;
  endtask

  task automatic drive_reqs();
    logic [19:0] ra;
    for (int i = 0; i < N_REQ; i++) begin
      if (rand_arm) begin
        if (!pending[i] && $urandom_range(0, 3) == 0) begin
          ra = ($urandom_range(0, 3) == 0) ? 20'hFFFFE : 20'($urandom);
          arm(i, ra, $urandom_range(0, 5));
        end else if (pending[i] && p_len[i] == 0 && $urandom_range(0, 7) == 0) begin
          pending[i] = 0;
        end
      end
      req[i] = pending[i];
      req_addr[i*20 +: 20]       = pending[i] ? p_addr[i] : 20'($urandom);
      req_len[i*LEN_W +: LEN_W]  = pending[i] ? LEN_W'(p_len[i]) : LEN_W'($urandom);
    end
    if (rst_at_d >= 0 && m_active && (cyc - m_g) == rst_at_d) begin
      Reset    = 1'b1;
      rst_at_d = -1;
    end else begin
      Reset = hold_rst;
    end
  endtask

  task automatic model_step();
    int i;
    if (Reset) begin
      m_active   = 0;
      m_rr       = 0;
      m_err      = 0;
      m_rst_prev = 1;
      return;
    end
    m_rst_prev = 0;
    if (m_active) begin
      if (cyc - m_g != burst_end()) return;
      m_active = 0;
    end
    for (int off = 0; off < N_REQ; off++) begin
      i = (m_rr + off) % N_REQ;
      if (req[i] && req_len[i*LEN_W +: LEN_W] != '0) begin
        m_active   = 1;
        m_g        = cyc + 1;
        m_owner    = i;
        m_base     = req_addr[i*20 +: 20];
        m_len      = int'(req_len[i*LEN_W +: LEN_W]);
        m_tmo      = !resp_en;
        m_rr       = (i + 1) % N_REQ;
        pending[i] = 0;
        break;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge Clk);
      cyc++;
      check_outputs();
      drive_ctrl();
      drive_reqs();
      model_step();
    end
  endtask

  initial begin
    Reset = 1'b1; req = '0; req_addr = '0; req_len = '0;
    done_r = 1'b0; OUTPUT_DATA = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pending[i] = 0; p_addr[i] = '0; p_len[i] = 0;
    end
    run(2);
    hold_rst = 0;

    arm(0, 20'h00100, 3);
    run(15);

    for (int r = 0; r < 4; r++) begin
      arm(0, 20'h01000 + 20'(r * 16), 2);
      arm(1, 20'h02000 + 20'(r * 16), 2);
      run(16);
    end

    arm(1, 20'h00400, 0);
    run(20);
    pending[1] = 0;

    resp_en = 0;
    arm(0, 20'h00ABC, 3);
    run(25);
    resp_en = 1;
    arm(1, 20'h00200, 2);
    run(12);

    arm(0, 20'hFFFFF, 2);
    run(12);

    arm(0, 20'h00300, 4);
    rst_at_d = 5;
    run(10);
    arm(0, 20'h00500, 1);
    arm(1, 20'h00600, 1);
    run(12);

    rand_arm = 1;
    stray_en = 1;
    run(3000);
    rand_arm = 0;
    stray_en = 0;
    for (int i = 0; i < N_REQ; i++) pending[i] = 0;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
